// File: rtl/pair_sweep_pkg.sv
// Shared types and constants for the paired even/odd address sweep sequencer.
package pair_sweep_pkg;

  localparam int unsigned PAIR_W   = 13;
  localparam int unsigned ADDR_W   = PAIR_W + 1;
  localparam int unsigned DEF_BASE = 6144;
  localparam int unsigned DEF_END  = 6656;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
  } addr_pair_t;

  // Even address on port A, odd neighbour on port B.
  function automatic addr_pair_t form_pair(input logic [PAIR_W-1:0] ptr);
    addr_pair_t p;
    p.a = {ptr, 1'b0};
    p.b = {ptr, 1'b1};
    return p;
  endfunction

endpackage

// File: rtl/pair_addr_gen.sv
// Pair pointer register; load takes priority over increment.
module pair_addr_gen (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_load,
  input  logic [pair_sweep_pkg::PAIR_W-1:0] i_load_val,
  input  logic                             i_inc,
  output logic [pair_sweep_pkg::PAIR_W-1:0] o_ptr,
  output logic [pair_sweep_pkg::ADDR_W-1:0] o_addr_a,
  output logic [pair_sweep_pkg::ADDR_W-1:0] o_addr_b
);
  import pair_sweep_pkg::*;

  logic [PAIR_W-1:0] r_ptr;
  addr_pair_t        w_pair;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= r_ptr + PAIR_W'(1);
    end
  end

  assign w_pair   = form_pair(r_ptr);
  assign o_ptr    = r_ptr;
  assign o_addr_a = w_pair.a;
  assign o_addr_b = w_pair.b;

endmodule

// File: rtl/pair_sweep_ctrl.sv
// Sweep sequencer: latches a pair range on start and hands out (even, odd) pairs under valid/ready.
// Optional macro PAIR_SWEEP_LOOP_EN adds i_loop for gapless range repetition.
module pair_sweep_ctrl #(
  parameter int unsigned DEF_BASE = pair_sweep_pkg::DEF_BASE,
  parameter int unsigned DEF_END  = pair_sweep_pkg::DEF_END
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic                             i_cfg_use_def,
  input  logic [pair_sweep_pkg::PAIR_W-1:0] i_cfg_base,
  input  logic [pair_sweep_pkg::PAIR_W-1:0] i_cfg_end,
  input  logic                             i_rdy,
`ifdef PAIR_SWEEP_LOOP_EN
  input  logic                             i_loop,
`endif
  output logic                             o_valid,
  output logic [pair_sweep_pkg::ADDR_W-1:0] o_addr_a,
  output logic [pair_sweep_pkg::ADDR_W-1:0] o_addr_b,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_cfg_err
);
  import pair_sweep_pkg::*;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PAIR_W-1:0] r_base_l;
  logic [PAIR_W-1:0] r_end_l;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_cfg_err;

  logic [PAIR_W-1:0] w_sel_base;
  logic [PAIR_W-1:0] w_sel_end;
  logic [PAIR_W-1:0] w_ptr;
  logic [PAIR_W-1:0] w_load_val;
  logic              w_empty;
  logic              w_last;
  logic              w_latch;
  logic              w_load;
  logic              w_inc;
  logic              w_loop_done;
  logic              w_loop;

  assign w_sel_base = i_cfg_use_def ? PAIR_W'(DEF_BASE) : i_cfg_base;
  assign w_sel_end  = i_cfg_use_def ? PAIR_W'(DEF_END)  : i_cfg_end;
  assign w_empty    = (w_sel_end <= w_sel_base);
  // Only evaluated in RUN, where end_l > base_l, so the decrement cannot underflow.
  assign w_last     = (w_ptr == (r_end_l - PAIR_W'(1)));
  assign w_load_val = w_latch ? w_sel_base : r_base_l;

`ifdef PAIR_SWEEP_LOOP_EN
  assign w_loop = i_loop;
`else
  assign w_loop = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_loop_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_latch = 1'b1;
          if (w_empty) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = RUN;
            w_load      = 1'b1;
          end
        end
      end
      RUN: begin
        if (i_abort) begin
          w_state_nxt = IDLE;
        end else if (i_rdy) begin
          if (w_last) begin
            if (w_loop) begin
              w_load      = 1'b1;
              w_loop_done = 1'b1;
            end else begin
              w_state_nxt = DONE;
            end
          end else begin
            w_inc = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_base_l  <= '0;
      r_end_l   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == RUN);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE) || w_loop_done;
      if (w_latch) begin
        r_base_l  <= w_sel_base;
        r_end_l   <= w_sel_end;
        r_cfg_err <= w_empty;
      end
    end
  end

  pair_addr_gen u_addr_gen (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_inc      (w_inc),
    .o_ptr      (w_ptr),
    .o_addr_a   (o_addr_a),
    .o_addr_b   (o_addr_b)
  );

  assign o_valid   = r_valid;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_pair_sweep_ctrl.sv
// Directed bench for pair_sweep_ctrl; build with +define+PAIR_SWEEP_LOOP_EN to cover looping.
module tb_pair_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        use_def;
  logic [12:0] cfg_base;
  logic [12:0] cfg_end;
  logic        rdy;
  logic        loop;
  logic        valid;
  logic [13:0] addr_a;
  logic [13:0] addr_b;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  pair_sweep_ctrl dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_cfg_use_def (use_def),
    .i_cfg_base    (cfg_base),
    .i_cfg_end     (cfg_end),
    .i_rdy         (rdy),
`ifdef PAIR_SWEEP_LOOP_EN
    .i_loop        (loop),
`endif
    .o_valid       (valid),
    .o_addr_a      (addr_a),
    .o_addr_b      (addr_b),
    .o_busy        (busy),
    .o_done        (done),
    .o_cfg_err     (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic def, input int unsigned b, input int unsigned e);
    use_def  = def;
    cfg_base = 13'(b);
    cfg_end  = 13'(e);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  int unsigned bp_exp[7] = '{20, 22, 22, 22, 24, 24, 24};

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; use_def = 1'b0;
    cfg_base = '0; cfg_end = '0; rdy = 1'b0; loop = 1'b0;
    #3;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_addr_b", 32'(addr_b), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Default range, no backpressure: 512 back-to-back beats.
    rdy = 1'b1;
    launch(1'b1, 0, 0);
    for (int i = 0; i < 512; i++) begin
      chk("def_valid", 32'(valid), 1);
      chk("def_addr_a", 32'(addr_a), 32'(12288 + 2 * i));
      if (i == 0 || i == 511) chk("def_addr_b", 32'(addr_b), 32'(12289 + 2 * i));
      chk("def_done_early", 32'(done), 0);
      tick();
    end
    chk("def_done", 32'(done), 1);
    chk("def_valid_off", 32'(valid), 0);
    chk("def_busy_done", 32'(busy), 1);
    tick();
    chk("def_done_clr", 32'(done), 0);
    chk("def_busy_clr", 32'(busy), 0);

    // Backpressure with rdy pattern 1,0,0,1,...
    launch(1'b0, 10, 13);
    for (int k = 0; k < 7; k++) begin
      rdy = (k % 3 == 0);
      chk("bp_valid", 32'(valid), 1);
      chk("bp_addr_a", 32'(addr_a), bp_exp[k]);
      chk("bp_done_early", 32'(done), 0);
      tick();
    end
    chk("bp_done", 32'(done), 1);
    chk("bp_valid_off", 32'(valid), 0);
    tick();
    chk("bp_busy_clr", 32'(busy), 0);

    // Empty range, then a valid start clears the sticky error.
    rdy = 1'b1;
    launch(1'b0, 100, 100);
    chk("empty_valid", 32'(valid), 0);
    chk("empty_cfg_err", 32'(cfg_err), 1);
    chk("empty_done", 32'(done), 1);
    tick();
    chk("empty_done_clr", 32'(done), 0);
    chk("empty_busy_clr", 32'(busy), 0);
    chk("empty_err_sticky", 32'(cfg_err), 1);
    launch(1'b0, 0, 1);
    chk("one_cfg_err", 32'(cfg_err), 0);
    chk("one_valid", 32'(valid), 1);
    chk("one_addr_a", 32'(addr_a), 0);
    chk("one_addr_b", 32'(addr_b), 1);
    tick();
    chk("one_done", 32'(done), 1);
    chk("one_valid_off", 32'(valid), 0);
    tick();

    // Abort on the fourth beat.
    launch(1'b0, 0, 8);
    for (int i = 0; i < 3; i++) begin
      chk("ab_addr_a", 32'(addr_a), 32'(2 * i));
      tick();
    end
    abort = 1'b1;
    chk("ab_addr_4th", 32'(addr_a), 6);
    tick();
    abort = 1'b0;
    chk("ab_valid", 32'(valid), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_ptr_hold", 32'(addr_a), 6);
    tick();
    chk("ab_done_later", 32'(done), 0);

    // Abort coincident with the final beat.
    launch(1'b0, 0, 2);
    chk("abf_addr0", 32'(addr_a), 0);
    tick();
    chk("abf_addr1", 32'(addr_a), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abf_valid", 32'(valid), 0);
    chk("abf_done", 32'(done), 0);
    chk("abf_busy", 32'(busy), 0);
    tick();
    chk("abf_done_later", 32'(done), 0);

    // Reset in the middle of a default sweep at ptr 6200.
    launch(1'b1, 0, 0);
    for (int i = 0; i < 56; i++) tick();
    chk("mr_addr_a_pre", 32'(addr_a), 12400);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(valid), 0);
    chk("mr_addr_a", 32'(addr_a), 0);
    chk("mr_addr_b", 32'(addr_b), 1);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    #3;
    rst = 1'b1;
    tick();
    tick();
    chk("mr_idle_valid", 32'(valid), 0);
    chk("mr_idle_busy", 32'(busy), 0);
    chk("mr_idle_addr", 32'(addr_a), 0);

`ifdef PAIR_SWEEP_LOOP_EN
    // Looping over base=4, end=6, then release loop.
    loop = 1'b1;
    launch(1'b0, 4, 6);
    chk("lp_a0", 32'(addr_a), 8);
    chk("lp_d0", 32'(done), 0);
    tick();
    chk("lp_a1", 32'(addr_a), 10);
    chk("lp_d1", 32'(done), 0);
    tick();
    chk("lp_a2", 32'(addr_a), 8);
    chk("lp_v2", 32'(valid), 1);
    chk("lp_d2", 32'(done), 1);
    tick();
    chk("lp_a3", 32'(addr_a), 10);
    chk("lp_d3", 32'(done), 0);
    loop = 1'b0;
    tick();
    chk("lp_stop_valid", 32'(valid), 0);
    chk("lp_stop_done", 32'(done), 1);
    tick();
    chk("lp_stop_busy", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
